// File: rtl/dynamics_scheduler.sv
// Shared envelope-scaling datapath: per-voice decaying level, round-robin request arbitration.
// Optional attack ramp compiled in with `define DYNAMICS_ATTACK_EN.
module dynamics_scheduler #(
    parameter int NUM_VOICES = 3,
    parameter int STEP_SCALE = 4,
    parameter int CNT_W      = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       generate_next_sample,
    input  logic [NUM_VOICES-1:0]      note_start,
    input  logic [6*NUM_VOICES-1:0]    note_duration,
    input  logic [NUM_VOICES-1:0]      sample_valid,
    input  logic [16*NUM_VOICES-1:0]   sample_in,
    output logic [NUM_VOICES-1:0]      sample_ack,
    output logic                       out_valid,
    output logic [2:0]                 out_voice,
    output logic signed [15:0]         out_sample,
    output logic [NUM_VOICES-1:0]      voice_active
);

    typedef enum logic [1:0] {IDLE, ATTACK, DECAY, DONE} voice_state_e;

    if (NUM_VOICES < 2 || NUM_VOICES > 8) begin : g_bad_num_voices
        $error("NUM_VOICES must be in 2..8");
    end
    if (STEP_SCALE < 1 ||
        longint'(63) * longint'(STEP_SCALE) * 128 >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for the longest decay interval");
    end

    logic [3:0] level [NUM_VOICES];

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        voice_state_e     state_q, state_d;
        logic [3:0]       level_q, level_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [5:0]       dur_q, dur_d;
        logic             active_q;
        logic [2:0]       stage;
        logic [CNT_W-1:0] interval;

        // Stage only matters in DECAY, where level is 1..8.
        assign stage    = 3'(4'd8 - level_q);
        assign interval = (CNT_W'(dur_q) * CNT_W'(STEP_SCALE)) << stage;

        always_comb begin
            // NOTE: every comb output gets a default first so no path can infer a latch.
            state_d = state_q;
            level_d = level_q;
            cnt_d   = cnt_q;
            dur_d   = dur_q;
            if (note_start[v]) begin
                dur_d = note_duration[6*v +: 6];
                cnt_d = '0;
                if (note_duration[6*v +: 6] == 6'd0) begin
                    state_d = DONE;
                    level_d = 4'd0;
                end else begin
`ifdef DYNAMICS_ATTACK_EN
                    state_d = ATTACK;
                    level_d = 4'd0;
`else
                    state_d = DECAY;
                    level_d = 4'd8;
`endif
                end
            end else if (generate_next_sample) begin
                case (state_q)
                    ATTACK: begin
                        level_d = level_q + 4'd1;
                        cnt_d   = '0;
                        if (level_q == 4'd7) state_d = DECAY;
                    end
                    DECAY: begin
                        if (cnt_q == interval - CNT_W'(1)) begin
                            cnt_d   = '0;
                            level_d = level_q - 4'd1;
                            if (level_q == 4'd1) state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    DONE:    state_d = IDLE;
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q  <= IDLE;
                level_q  <= 4'd0;
                cnt_q    <= '0;
                dur_q    <= '0;
                active_q <= 1'b0;
            end else begin
                // NOTE: sequential state uses non-blocking assignment so all flops see pre-edge values.
                state_q  <= state_d;
                level_q  <= level_d;
                cnt_q    <= cnt_d;
                dur_q    <= dur_d;
                active_q <= (level_d != 4'd0) || (state_d == ATTACK);
            end
        end

        assign level[v]        = level_q;
        assign voice_active[v] = active_q;
    end

    logic [NUM_VOICES-1:0] last_ack_q;
    logic [NUM_VOICES-1:0] eligible;
    logic [NUM_VOICES-1:0] grant;
    logic [2:0]            rr_ptr_q;
    logic [2:0]            grant_idx;
    logic [3:0]            scan_idx;
    logic                  grant_any;

    // Last cycle's grantee sits out one cycle so it can drop its request.
    always_comb begin
        eligible  = sample_valid & ~last_ack_q;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            scan_idx = 4'(rr_ptr_q) + 4'(i);
            if (scan_idx >= 4'(NUM_VOICES)) scan_idx = scan_idx - 4'(NUM_VOICES);
            for (int j = 0; j < NUM_VOICES; j++) begin
                if (!grant_any && scan_idx == 4'(j) && eligible[j]) begin
                    grant_any = 1'b1;
                    grant_idx = 3'(j);
                end
            end
        end
        for (int j = 0; j < NUM_VOICES; j++) begin
            grant[j] = grant_any && (grant_idx == 3'(j));
        end
    end

    // The ack is combinational, so it must also be held low while reset is asserted.
    assign sample_ack = grant & {NUM_VOICES{reset}};

    logic signed [15:0] sel_sample;
    logic [3:0]         sel_level;
    logic signed [19:0] sample_ext;
    logic signed [19:0] level_ext;
    logic signed [19:0] product;
    logic signed [15:0] scaled;

    always_comb begin
        sel_sample = '0;
        sel_level  = '0;
        for (int j = 0; j < NUM_VOICES; j++) begin
            if (grant[j]) begin
                sel_sample = $signed(sample_in[16*j +: 16]);
                sel_level  = level[j];
            end
        end
    end

    assign sample_ext = {{4{sel_sample[15]}}, sel_sample};
    assign level_ext  = {16'd0, sel_level};
    assign product    = sample_ext * level_ext;
    assign scaled     = 16'(product >>> 3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_voice  <= 3'd0;
            out_sample <= 16'sd0;
            rr_ptr_q   <= 3'd0;
            last_ack_q <= '0;
        end else begin
            out_valid  <= grant_any;
            last_ack_q <= grant;
            if (grant_any) begin
                out_voice  <= grant_idx;
                out_sample <= scaled;
                rr_ptr_q   <= (grant_idx == 3'(NUM_VOICES - 1)) ? 3'd0 : grant_idx + 3'd1;
            end
        end
    end

endmodule
